// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential-multiplier sequencer: default widths and FSM states.
package mul_seq_pkg;
  localparam int OP_W_DEF  = 8;
  localparam int RES_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    DONE
  } state_t;
endpackage

// File: rtl/mul_seq.sv
// Sequencer for an external repeated-add multiplier: buffers one operand pair,
// loads the multiplier, waits op_b+1 run cycles, then holds the product for the consumer.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             mul_load,
  output logic [OP_W-1:0]  mul_a,
  output logic [OP_W-1:0]  mul_b,
  input  logic [RES_W-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [OP_W-1:0]    pend_a_q, pend_a_d;
  logic [OP_W-1:0]    pend_b_q, pend_b_d;
  logic               pend_full_q, pend_full_d;
  logic [OP_W-1:0]    op_a_q, op_a_d;
  logic [OP_W-1:0]    op_b_q, op_b_d;
  logic [OP_W-1:0]    cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   out_data_q, out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      pend_full_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      pend_full_q <= pend_full_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    pend_full_d = pend_full_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          op_a_d      = pend_a_q;
          op_b_d      = pend_b_q;
          pend_full_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = op_b_q;
        state_d = RUN;
      end
      RUN: begin
        // Counter stops at zero, so it never wraps even for op_b = all ones.
        if (cnt_q == '0) state_d = CAPT;
        else             cnt_d   = cnt_q - OP_W'(1);
      end
      CAPT: begin
        out_data_d  = mul_result;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only into an empty buffer; a drain above can never coincide with it.
    if (in_valid && !pend_full_q) begin
      pend_a_d    = in_a;
      pend_b_d    = in_b;
      pend_full_d = 1'b1;
    end
  end

  assign in_ready  = !pend_full_q;
  assign mul_load  = (state_q != LOAD);
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// Randomized and directed check of mul_seq against a product/latency/order reference,
// with a behavioural repeated-add multiplier attached to the multiplier port.
module tb_mul_seq;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a, in_b;
  logic             mul_load;
  logic [OP_W-1:0]  mul_a, mul_b;
  logic [RES_W-1:0] mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic             busy;

  mul_seq #(.OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Repeated-add multiplier: load=0 captures, load=1 adds a once per edge while count remains.
  logic [RES_W-1:0] m_acc = '0;
  logic [OP_W-1:0]  m_a = '0, m_cnt = '0;
  always @(posedge clk) begin
    if (!mul_load) begin
      m_acc <= '0;
      m_a   <= mul_a;
      m_cnt <= mul_b;
    end else if (m_cnt != '0) begin
      m_acc <= m_acc + RES_W'(m_a);
      m_cnt <= m_cnt - OP_W'(1);
    end
  end
  assign mul_result = m_acc;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    int unsigned     prod;
    int              acc_cyc;
    bit              chk_lat;
  } txn_t;

  txn_t exp_q[$];
  int   cyc = 0;
  int   load_lows = 0;
  bit   prev_valid = 0, prev_hs = 0;
  logic [RES_W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, between driver updates and the next active edge.
  always @(negedge clk) begin
    bit   hs;
    txn_t t;
    if (!rst_n) begin
      exp_q.delete();
      prev_valid = 0;
      prev_hs    = 0;
    end else begin
      if (!mul_load) begin
        load_lows++;
        if (exp_q.size() > 0) begin
          chk("mul_a_load", mul_a, exp_q[0].a);
          chk("mul_b_load", mul_b, exp_q[0].b);
        end else chk("load_without_txn", 1, 0);
      end
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else if (exp_q[0].chk_lat)
          chk("latency", cyc - exp_q[0].acc_cyc, exp_q[0].b + 4);
      end
      if (out_valid && prev_valid && !prev_hs) chk("out_stable", out_data, prev_data);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() > 0) begin
          chk("product", out_data, exp_q[0].prod);
          $display("txn a=%0d b=%0d out=%0d exp=%0d", exp_q[0].a, exp_q[0].b, out_data, exp_q[0].prod);
          void'(exp_q.pop_front());
        end else chk("extra_output", 1, 0);
      end
      if (in_valid && in_ready) begin
        t.a       = in_a;
        t.b       = in_b;
        t.prod    = int'(in_a) * int'(in_b);
        t.acc_cyc = cyc + 1;
        t.chk_lat = !busy;
        exp_q.push_back(t);
      end
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_hs    = hs;
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int waitc = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waitc++;
      if (waitc > 2000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= limit) chk("drain_timeout", 0, 1);
  endtask

  bit rnd_done = 0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mul_load", mul_load, 1);
    chk("rst_busy", busy, 0);

    // First accept right after reset release: 20*23
    load_lows = 0;
    in_valid = 1'b1; in_a = 8'd20; in_b = 8'd23;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_accept", in_ready, 0);
    in_valid = 1'b0;
    drain(100);
    chk("load_pulse_len", load_lows, 1);

    send(8'd7, 8'd0);
    drain(100);
    send(8'd255, 8'd255);
    drain(400);

    // Back-to-back with consumer stalled 10 cycles after first result
    out_ready = 1'b0;
    fork
      begin
        send(8'd20, 8'd23);
        send(8'd7, 8'd0);
        chk("in_ready_full", in_ready, 0);
        send(8'd255, 8'd255);
      end
      begin
        int n = 0;
        while (!out_valid && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 200) chk("first_valid_timeout", 0, 1);
        repeat (10) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(800);

    // Reset in the middle of RUN
    send(8'd20, 8'd23);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_mul_load", mul_load, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd3, 8'd4);
    drain(100);

    // Random traffic with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [OP_W-1:0] ra, rb;
          int gap;
          ra = OP_W'($urandom_range(0, 255));
          rb = ($urandom_range(0, 7) == 0) ? OP_W'($urandom_range(0, 255))
                                           : OP_W'($urandom_range(0, 12));
          send(ra, rb);
          gap = $urandom_range(0, 3);
          repeat (gap) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain(3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
